// File: rtl/key_scan_ctrl_if.sv
// Keypad scanner bus: decoder drive, column returns and the key-code valid/ready handshake.
// master = scanner side, slave = keypad/consumer side.
interface key_scan_ctrl_if;
    logic       en;
    logic [2:0] a;
    logic [2:0] s;
    logic [3:0] col;
    logic [4:0] code;
    logic       valid;
    logic       ready;

    modport master (
        input  en,
        input  col,
        input  ready,
        output a,
        output s,
        output code,
        output valid
    );

    modport slave (
        output en,
        output col,
        output ready,
        input  a,
        input  s,
        input  code,
        input  valid
    );
endinterface

// File: rtl/key_scan_ctrl.sv
// Matrix-keypad scanner driving a 3-to-8 row decoder, with press/release debounce and a
// valid/ready key-code output. Optional auto-repeat is built when KEYSCAN_REPEAT_EN is defined.
module key_scan_ctrl #(
    parameter int unsigned DWELL    = 4,
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned REPEAT   = 64
) (
    input logic             clk,
    input logic             rst,
    key_scan_ctrl_if.master bus
);
    localparam int unsigned DwW  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned CntW = $clog2(DEBOUNCE + 1);

    if (DWELL < 2 || DEBOUNCE < 2 || REPEAT < 1) begin : g_bad_param
        $error("key_scan_ctrl: DWELL and DEBOUNCE must be >= 2, REPEAT >= 1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StConfirm,
        StHold,
        StRelease
    } state_e;

    state_e            r_state;
    logic   [2:0]      r_row;
    logic   [DwW-1:0]  r_dwell;
    logic   [CntW-1:0] r_cnt;
    logic   [4:0]      r_cand;
    logic   [4:0]      r_code;
    logic              r_valid;
    logic   [2:0]      r_s;

    state_e            w_state_d;
    logic   [2:0]      w_row_d;
    logic   [DwW-1:0]  w_dwell_d;
    logic   [CntW-1:0] w_cnt_d;
    logic   [4:0]      w_cand_d;
    logic   [4:0]      w_code_d;
    logic              w_valid_d;
    logic   [2:0]      w_s_d;

    logic              w_hit;
    logic   [1:0]      w_idx;
    logic   [4:0]      w_key;
    logic              w_dwell_end;
    logic   [CntW-1:0] w_cnt_inc;
    logic              w_cnt_done;

`ifdef KEYSCAN_REPEAT_EN
    localparam int unsigned RptW = $clog2(REPEAT + 1);

    logic   [RptW-1:0] r_rpt;
    logic   [RptW-1:0] w_rpt_d;
`endif

    // Column 0 has the highest priority when several columns are pulled low.
    always_comb begin
        w_idx = 2'd3;
        if (!bus.col[0]) begin
            w_idx = 2'd0;
        end else if (!bus.col[1]) begin
            w_idx = 2'd1;
        end else if (!bus.col[2]) begin
            w_idx = 2'd2;
        end
    end

    assign w_hit       = (bus.col != 4'hF);
    assign w_key       = {r_row, w_idx};
    assign w_dwell_end = (r_dwell == DwW'(DWELL - 1));
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_cnt_done  = (w_cnt_inc == CntW'(DEBOUNCE));

    always_comb begin
        w_state_d = r_state;
        w_row_d   = r_row;
        w_dwell_d = r_dwell;
        w_cnt_d   = r_cnt;
        w_cand_d  = r_cand;
        w_code_d  = r_code;
        w_valid_d = r_valid;
        w_s_d     = r_s;
`ifdef KEYSCAN_REPEAT_EN
        w_rpt_d   = r_rpt;
`endif

        unique case (r_state)
            StIdle: begin
                if (bus.en) begin
                    w_state_d = StScan;
                    w_row_d   = 3'd0;
                    w_dwell_d = '0;
                    w_s_d     = 3'b001;
                end
            end

            StScan: begin
                if (!bus.en) begin
                    w_state_d = StIdle;
                    w_row_d   = 3'd0;
                    w_dwell_d = '0;
                    w_s_d     = 3'b000;
                end else if (w_dwell_end) begin
                    w_dwell_d = '0;
                    if (w_hit) begin
                        w_state_d = StConfirm;
                        w_cand_d  = w_key;
                        w_cnt_d   = CntW'(1);
                    end else begin
                        w_row_d = r_row + 3'd1;
                    end
                end else begin
                    w_dwell_d = r_dwell + 1'b1;
                end
            end

            StConfirm: begin
                if (w_hit && (w_key == r_cand)) begin
                    if (w_cnt_done) begin
                        w_state_d = StHold;
                        w_code_d  = r_cand;
                        w_valid_d = 1'b1;
                    end else begin
                        w_cnt_d = w_cnt_inc;
                    end
                end else begin
                    w_state_d = StScan;
                    w_row_d   = r_row + 3'd1;
                    w_dwell_d = '0;
                end
            end

            StHold: begin
                if (bus.ready) begin
                    w_state_d = StRelease;
                    w_valid_d = 1'b0;
                    w_cnt_d   = '0;
`ifdef KEYSCAN_REPEAT_EN
                    w_rpt_d   = '0;
`endif
                end
            end

            StRelease: begin
                if (!w_hit) begin
                    if (w_cnt_done) begin
                        w_state_d = StScan;
                        w_row_d   = r_row + 3'd1;
                        w_dwell_d = '0;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = w_cnt_inc;
                    end
`ifdef KEYSCAN_REPEAT_EN
                    w_rpt_d = '0;
`endif
                end else begin
                    w_cnt_d = '0;
`ifdef KEYSCAN_REPEAT_EN
                    // A key still held on the same column re-fires after REPEAT cycles.
                    if (w_key == r_code) begin
                        if ((r_rpt + 1'b1) == RptW'(REPEAT)) begin
                            w_state_d = StHold;
                            w_valid_d = 1'b1;
                            w_rpt_d   = '0;
                        end else begin
                            w_rpt_d = r_rpt + 1'b1;
                        end
                    end else begin
                        w_rpt_d = '0;
                    end
`endif
                end
            end

            default: begin
                w_state_d = StIdle;
                w_row_d   = 3'd0;
                w_dwell_d = '0;
                w_cnt_d   = '0;
                w_valid_d = 1'b0;
                w_s_d     = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_row   <= 3'd0;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_cand  <= 5'd0;
            r_code  <= 5'd0;
            r_valid <= 1'b0;
            r_s     <= 3'b000;
        end else begin
            r_state <= w_state_d;
            r_row   <= w_row_d;
            r_dwell <= w_dwell_d;
            r_cnt   <= w_cnt_d;
            r_cand  <= w_cand_d;
            r_code  <= w_code_d;
            r_valid <= w_valid_d;
            r_s     <= w_s_d;
        end
    end

`ifdef KEYSCAN_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rpt <= '0;
        end else begin
            r_rpt <= w_rpt_d;
        end
    end
`endif

    assign bus.a     = r_row;
    assign bus.s     = r_s;
    assign bus.code  = r_code;
    assign bus.valid = r_valid;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed bench for key_scan_ctrl (DWELL=4, DEBOUNCE=3, REPEAT=64); a keypad model drives the
// column returns from the strobed row. Repeat checks follow KEYSCAN_REPEAT_EN.
module tb_key_scan_ctrl;
    logic clk;
    logic rst;

    key_scan_ctrl_if bus ();

    key_scan_ctrl #(
        .DWELL    (4),
        .DEBOUNCE (3),
        .REPEAT   (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks;
    int unsigned n_errors;

    logic       key_on;
    logic [2:0] key_row;
    logic [3:0] key_pat;
    logic       ovr_en;
    logic [3:0] ovr_col;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a pressed key only pulls its column low while its row is strobed.
    always_comb begin
        if (ovr_en) begin
            bus.col = ovr_col;
        end else if (key_on && (bus.s == 3'b001) && (bus.a == key_row)) begin
            bus.col = key_pat;
        end else begin
            bus.col = 4'hF;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves en high just before edge 0; the next step() lands in cycle 1.
    task automatic restart();
        rst    = 1'b1;
        bus.en = 1'b0;
        step();
        step();
        rst    = 1'b0;
        bus.en = 1'b1;
    endtask

    int unsigned n_valid;
    int unsigned first_cyc;
    logic [4:0]  rpt_code;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        bus.en    = 1'b0;
        bus.ready = 1'b0;
        key_on    = 1'b0;
        key_row   = 3'd0;
        key_pat   = 4'hF;
        ovr_en    = 1'b0;
        ovr_col   = 4'hF;

        repeat (3) step();
        check_eq("reset_a", 32'(bus.a), 32'd0);
        check_eq("reset_s", 32'(bus.s), 32'd0);
        check_eq("reset_code", 32'(bus.code), 32'd0);
        check_eq("reset_valid", 32'(bus.valid), 32'd0);
        rst = 1'b0;
        step();
        check_eq("idle_s", 32'(bus.s), 32'd0);

        // Free-running scan, no keys: row r on cycles 4r+1..4r+4, wrapping after row 7.
        restart();
        for (int c = 1; c <= 36; c++) begin
            step();
            check_eq($sformatf("scan_s_c%0d", c), 32'(bus.s), 32'd1);
            check_eq($sformatf("scan_a_c%0d", c), 32'(bus.a), 32'(((c - 1) / 4) % 8));
            check_eq($sformatf("scan_valid_c%0d", c), 32'(bus.valid), 32'd0);
        end

        // en dropped mid-scan returns to idle on the next cycle.
        restart();
        repeat (6) step();
        check_eq("en_off_a_before", 32'(bus.a), 32'd1);
        bus.en = 1'b0;
        step();
        check_eq("en_off_s", 32'(bus.s), 32'd0);
        check_eq("en_off_a", 32'(bus.a), 32'd0);
        bus.en = 1'b1;

        // Row 2, column 1 with ready high: valid on cycle 15, code 5'h09, gone on 16.
        key_row   = 3'd2;
        key_pat   = 4'b1101;
        key_on    = 1'b1;
        bus.ready = 1'b1;
        restart();
        repeat (14) step();
        check_eq("press_valid_c14", 32'(bus.valid), 32'd0);
        step();
        check_eq("press_valid_c15", 32'(bus.valid), 32'd1);
        check_eq("press_code_c15", 32'(bus.code), 32'h09);
        step();
        check_eq("press_valid_c16", 32'(bus.valid), 32'd0);
        check_eq("release_a_c16", 32'(bus.a), 32'd2);
        key_on = 1'b0;
        step();
        step();
        check_eq("release_a_c18", 32'(bus.a), 32'd2);
        step();
        check_eq("release_a_c19", 32'(bus.a), 32'd3);
        check_eq("release_s_c19", 32'(bus.s), 32'd1);

        // Row 5, columns 0 and 3 down: column 0 wins, code 5'b10100 on cycle 27.
        key_row = 3'd5;
        key_pat = 4'b0110;
        key_on  = 1'b1;
        restart();
        repeat (26) step();
        check_eq("prio_valid_c26", 32'(bus.valid), 32'd0);
        step();
        check_eq("prio_valid_c27", 32'(bus.valid), 32'd1);
        check_eq("prio_code_c27", 32'(bus.code), 32'h14);
        key_on = 1'b0;

        // Glitch: low for the sample cycle plus one, then open; scanning moves to row 1.
        ovr_en  = 1'b1;
        ovr_col = 4'hF;
        restart();
        repeat (4) step();
        ovr_col = 4'b1110;
        step();
        step();
        check_eq("glitch_a_c6", 32'(bus.a), 32'd0);
        ovr_col = 4'hF;
        for (int c = 7; c <= 12; c++) begin
            step();
            check_eq($sformatf("glitch_valid_c%0d", c), 32'(bus.valid), 32'd0);
            check_eq($sformatf("glitch_a_c%0d", c), 32'(bus.a), (c <= 10) ? 32'd1 : 32'd2);
        end
        ovr_en = 1'b0;

        // Back-pressure: valid and code hold while ready is low; reset clears mid-HOLD.
        key_row   = 3'd2;
        key_pat   = 4'b1101;
        key_on    = 1'b1;
        bus.ready = 1'b0;
        restart();
        repeat (15) step();
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("stall_valid_%0d", i), 32'(bus.valid), 32'd1);
            check_eq($sformatf("stall_code_%0d", i), 32'(bus.code), 32'h09);
            step();
        end
        rst = 1'b1;
        step();
        check_eq("hold_rst_a", 32'(bus.a), 32'd0);
        check_eq("hold_rst_s", 32'(bus.s), 32'd0);
        check_eq("hold_rst_code", 32'(bus.code), 32'd0);
        check_eq("hold_rst_valid", 32'(bus.valid), 32'd0);
        rst = 1'b0;

        // Key held with ready high: one issue, plus a re-issue on cycle 80 if repeat is built.
        bus.ready = 1'b1;
        restart();
        repeat (15) step();
        check_eq("hold_first_valid", 32'(bus.valid), 32'd1);
        n_valid   = 0;
        first_cyc = 0;
        rpt_code  = 5'd0;
        for (int c = 16; c <= 100; c++) begin
            step();
            if (bus.valid) begin
                if (n_valid == 0) begin
                    first_cyc = c;
                    rpt_code  = bus.code;
                end
                n_valid++;
            end
        end
`ifdef KEYSCAN_REPEAT_EN
        check_eq("repeat_count", n_valid, 32'd1);
        check_eq("repeat_cycle", first_cyc, 32'd80);
        check_eq("repeat_code", 32'(rpt_code), 32'h09);
`else
        check_eq("single_issue_count", n_valid, 32'd0);
        check_eq("single_issue_a", 32'(bus.a), 32'd2);
`endif
        key_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
